io_display_ctrl: RTL

Memory-mapped I/O peripheral sitting directly downstream of the data memory's port space. It owns the display output port (P1) and the button/switch input ports (P2/P3). It latches the signed display word written by the CPU and drives a 4-digit multiplexed common-anode seven-segment display in signed decimal. It also synchronizes the switches, and debounces the push-button into a sticky "pressed" flag that the CPU reads and clears.

---
 rtl/io_pkg.sv | 59 +++++
 rtl/io_display_ctrl_debouncer.sv | 110 +++++++++++
 rtl/io_display_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// ---------------------------------------------------------------------------
// io_pkg
// Shared definitions for the display/button/switch I/O peripheral:
//   - seven-segment glyph constants (active-low {g,f,e,d,c,b,a})
//   - debounce FSM state type
//   - number of multiplexed digits
//   - binary-to-BCD conversion (shift-add-3, purely combinational)
// ---------------------------------------------------------------------------
package io_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // The converter handles magnitudes up to 511, which covers an 8-bit
    // signed word (largest magnitude 128) with room to spare.
    localparam int BCD_IN_W  = 9;
    localparam int BCD_OUT_W = 12;

    typedef enum logic [1:0] {
        DEB_IDLE,
        DEB_WAIT_HI,
        DEB_PRESSED,
        DEB_WAIT_LO
    } deb_state_t;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        if (d > 4'd9) begin
            g = SEG_BLANK;
        end else begin
            g = SEG_DIGIT[d];
        end
        return g;
    endfunction

    // Double-dabble: before each shift, any BCD nibble >= 5 gets +3 so the
    // shift carries correctly into the next decimal digit.
    function automatic logic [BCD_OUT_W-1:0] bin_to_bcd(input logic [BCD_IN_W-1:0] bin);
        logic [BCD_OUT_W+BCD_IN_W-1:0] sr;
        sr = {{BCD_OUT_W{1'b0}}, bin};
        for (int i = 0; i < BCD_IN_W; i++) begin
            for (int d = 0; d < BCD_OUT_W / 4; d++) begin
                if (sr[BCD_IN_W + 4*d +: 4] >= 4'd5) begin
                    sr[BCD_IN_W + 4*d +: 4] = sr[BCD_IN_W + 4*d +: 4] + 4'd3;
                end
            end
            sr = sr << 1;
        end
        return sr[BCD_OUT_W+BCD_IN_W-1:BCD_IN_W];
    endfunction

endpackage

// File: rtl/io_display_ctrl_debouncer.sv
// ---------------------------------------------------------------------------
// debouncer
// Synchronizes an asynchronous active-high push-button and debounces it.
// Emits a single-cycle press pulse on each accepted press (low -> high);
// holding the button never produces a second pulse.
//   clk, rst_n   : clock, asynchronous active-low reset
//   btn_raw      : raw button input (asynchronous)
//   press_pulse  : registered one-cycle pulse on an accepted press
// ---------------------------------------------------------------------------
module debouncer
    import io_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             btn_meta_q, btn_meta_d;
    logic             btn_sync_q, btn_sync_d;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             armed_q, armed_d;

    // armed_q guards against a button held across reset: the synchronizer
    // comes out of reset reading 0, so without this the FSM would treat a
    // still-held button as a fresh press. After reset the button must read
    // low for DEB_CYCLES consecutive cycles before any press is accepted.
    always_comb begin
        btn_meta_d = btn_raw;
        btn_sync_d = btn_meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        pulse_d    = 1'b0;
        armed_d    = armed_q;

        case (state_q)
            DEB_IDLE: begin
                if (!armed_q) begin
                    if (btn_sync_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        armed_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (btn_sync_q) begin
                    state_d = DEB_WAIT_HI;
                    cnt_d   = '0;
                end
            end
            DEB_WAIT_HI: begin
                if (!btn_sync_q) begin
                    state_d = DEB_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DEB_PRESSED;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DEB_PRESSED: begin
                if (!btn_sync_q) begin
                    state_d = DEB_WAIT_LO;
                    cnt_d   = '0;
                end
            end
            DEB_WAIT_LO: begin
                if (btn_sync_q) begin
                    state_d = DEB_PRESSED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DEB_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DEB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            state_q    <= DEB_IDLE;
            cnt_q      <= '0;
            pulse_q    <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
            armed_q    <= armed_d;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/io_display_ctrl.sv
// ---------------------------------------------------------------------------
// io_display_ctrl
// Memory-mapped I/O peripheral: latches a signed display word and shows it
// in signed decimal on a 4-digit multiplexed common-anode seven-segment
// display; synchronizes switches; debounces the push-button into a sticky
// flag the CPU reads and clears.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write strobe for the display register
//   wr_data    : signed value to display
//   btn_clr    : CPU acknowledge, clears btn_flag
//   btn_raw    : raw push-button (asynchronous, active-high)
//   sw_raw     : raw switches (asynchronous)
//   btn_flag   : sticky debounced press flag
//   sw_sync    : synchronized switch value
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   an         : active-low digit enables, an[0] = rightmost digit
// ---------------------------------------------------------------------------
module io_display_ctrl
    import io_pkg::*;
#(
    parameter int N              = 8,
    parameter int DEB_CYCLES     = 500000,
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [N-1:0]          wr_data,
    input  logic                  btn_clr,
    input  logic                  btn_raw,
    input  logic [N-1:0]          sw_raw,
    output logic                  btn_flag,
    output logic [N-1:0]          sw_sync,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RF_W-1:0] RF_MAX = RF_W'(REFRESH_CYCLES - 1);

    logic [N-1:0]            disp_q, disp_d;
    logic [RF_W-1:0]         rf_cnt_q, rf_cnt_d;
    logic [1:0]              idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    btn_flag_q, btn_flag_d;
    logic [N-1:0]            sw_meta_q, sw_meta_d;
    logic [N-1:0]            sw_sync_q, sw_sync_d;

    logic                    press_pulse;
    logic                    neg;
    logic [N:0]              disp_ext;
    logic [N:0]              mag;
    logic [BCD_OUT_W-1:0]    bcd;
    logic [3:0]              hundreds, tens, ones;
    logic [6:0]              glyph [NUM_DIGITS];

    debouncer #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debouncer (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .press_pulse (press_pulse)
    );

    // Magnitude is one bit wider than the word so the most negative value
    // (e.g. -128) still produces its true magnitude.
    always_comb begin
        neg      = disp_q[N-1];
        disp_ext = {disp_q[N-1], disp_q};
        mag      = neg ? -disp_ext : disp_ext;
        bcd      = bin_to_bcd(BCD_IN_W'(mag));
        hundreds = bcd[11:8];
        tens     = bcd[7:4];
        ones     = bcd[3:0];

        glyph[0] = digit_glyph(ones);
        glyph[1] = (hundreds == 4'd0 && tens == 4'd0) ? SEG_BLANK : digit_glyph(tens);
        glyph[2] = (hundreds == 4'd0) ? SEG_BLANK : digit_glyph(hundreds);
        glyph[3] = neg ? SEG_MINUS : SEG_BLANK;
    end

    // seg/an are only reloaded on the cycle the refresh counter sits at 0,
    // i.e. the first edge of each digit slot. A write mid-slot therefore
    // cannot tear the lit digit; it shows from the next slot onward.
    always_comb begin
        disp_d     = wr_en ? wr_data : disp_q;
        rf_cnt_d   = rf_cnt_q;
        idx_d      = idx_q;
        seg_d      = seg_q;
        an_d       = an_q;
        btn_flag_d = press_pulse | (btn_flag_q & ~btn_clr);
        sw_meta_d  = sw_raw;
        sw_sync_d  = sw_meta_q;

        if (rf_cnt_q == RF_MAX) begin
            rf_cnt_d = '0;
            idx_d    = idx_q + 2'd1;
        end else begin
            rf_cnt_d = rf_cnt_q + RF_W'(1);
        end

        if (rf_cnt_q == '0) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = glyph[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q     <= '0;
            rf_cnt_q   <= '0;
            idx_q      <= 2'd0;
            seg_q      <= SEG_BLANK;
            an_q       <= '1;
            btn_flag_q <= 1'b0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            disp_q     <= disp_d;
            rf_cnt_q   <= rf_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            btn_flag_q <= btn_flag_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign btn_flag = btn_flag_q;
    assign sw_sync  = sw_sync_q;

endmodule
